// File: rtl/ascon_io_pkg.sv
// rtl/ascon_io_pkg.sv - shared state encoding and frame-length helper for the Ascon serial front end
package ascon_io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOADED,
      ST_RUN,
      ST_UNLOAD,
      ST_DONE
   } state_e;

   // The serial frame is as long as the widest operand, never shorter than the 128-bit nonce/tag.
   function automatic int frame_len(input int kk, input int ll, input int yy);
      int m;
      m = 128;
      if (kk > m) m = kk;
      if (ll > m) m = ll;
      if (yy > m) m = yy;
      return m;
   endfunction

endpackage

// File: rtl/ascon_lane_deser.sv
// rtl/ascon_lane_deser.sv - one operand lane: MSB-first shift register that only accepts its first W frame bits
module ascon_lane_deser #(
   parameter int W  = 128,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] idx,
   input  logic          din,
   output logic [W-1:0]  data
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   logic [W-1:0] base;

   // A clear and the first bit of the next frame arrive in the same cycle.
   always_comb begin
      base   = clr ? '0 : data_q;
      data_d = base;
      if (en && (idx < CW'(W))) begin
         data_d = {base[W-2:0], din};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/ascon_serial_io.sv
// rtl/ascon_serial_io.sv - serial load of key/nonce/AD/PT, start forwarding, serial unload of ciphertext and tag
module ascon_serial_io
   import ascon_io_pkg::*;
#(
   parameter int k = 128,
   parameter int l = 40,
   parameter int y = 96
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   keyxSI,
   input  logic [4:0]   noncexSI,
   input  logic [4:0]   associated_dataxSI,
   input  logic [4:0]   plain_textxSI,
   input  logic         load_enxSI,
   input  logic         startxSI,
   input  logic         read_enxSI,
   input  logic         core_readyxSI,
   input  logic [y-1:0] core_ctxDI,
   input  logic [127:0] core_tagxDI,
   output logic [k-1:0] keyxDO,
   output logic [127:0] noncexDO,
   output logic [l-1:0] adxDO,
   output logic [y-1:0] ptxDO,
   output logic         loadedxSO,
   output logic         core_startxSO,
   output logic         cipher_textxSO,
   output logic         tagxSO,
   output logic         out_validxSO
);

   localparam int MAX = frame_len(k, l, y);
   localparam int CW  = $clog2(MAX + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic            start_prev_q, start_prev_d;
   logic            core_start_q, core_start_d;
   logic            loaded_q, loaded_d;
   logic            out_valid_q, out_valid_d;
   logic [y-1:0]    ct_q, ct_d;
   logic [127:0]    tag_q, tag_d;

   logic            lane_en;
   logic            lane_clr;
   logic [CW-1:0]   lane_idx;
   logic            unused_pad;

   assign unused_pad = ^{keyxSI[4:1], noncexSI[4:1], associated_dataxSI[4:1], plain_textxSI[4:1]};

   always_comb begin
      state_d      = state_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      start_prev_d = startxSI;
      core_start_d = 1'b0;
      loaded_d     = loaded_q;
      out_valid_d  = out_valid_q;
      ct_d         = ct_q;
      tag_d        = tag_q;
      lane_en      = 1'b0;
      lane_clr     = 1'b0;
      lane_idx     = in_cnt_q;
      unique case (state_q)
         ST_IDLE, ST_LOAD, ST_DONE: begin
            if (load_enxSI) begin
               lane_en = 1'b1;
               // Loading after a completed run restarts the frame at bit 0 on fresh operands.
               if (state_q == ST_DONE) begin
                  lane_clr = 1'b1;
                  lane_idx = '0;
               end
               if (lane_idx == CW'(MAX - 1)) begin
                  state_d  = ST_LOADED;
                  loaded_d = 1'b1;
                  in_cnt_d = '0;
               end else begin
                  state_d  = ST_LOAD;
                  in_cnt_d = lane_idx + CW'(1);
               end
            end
         end
         ST_LOADED: begin
            if (startxSI && !start_prev_q) begin
               core_start_d = 1'b1;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            if (core_readyxSI) begin
               ct_d        = core_ctxDI;
               tag_d       = core_tagxDI;
               out_cnt_d   = '0;
               out_valid_d = 1'b1;
               state_d     = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            if (read_enxSI) begin
               ct_d      = ct_q >> 1;
               tag_d     = tag_q >> 1;
               out_cnt_d = out_cnt_q + CW'(1);
               if (out_cnt_q == CW'(MAX - 1)) begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
                  loaded_d    = 1'b0;
                  ct_d        = '0;
                  tag_d       = '0;
                  out_cnt_d   = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         start_prev_q <= 1'b0;
         core_start_q <= 1'b0;
         loaded_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         ct_q         <= '0;
         tag_q        <= '0;
      end else begin
         state_q      <= state_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         start_prev_q <= start_prev_d;
         core_start_q <= core_start_d;
         loaded_q     <= loaded_d;
         out_valid_q  <= out_valid_d;
         ct_q         <= ct_d;
         tag_q        <= tag_d;
      end
   end

   ascon_lane_deser #(.W(k), .CW(CW)) u_key (
      .clk(clk), .rst(rst), .clr(lane_clr), .en(lane_en), .idx(lane_idx),
      .din(keyxSI[0]), .data(keyxDO)
   );

   ascon_lane_deser #(.W(128), .CW(CW)) u_nonce (
      .clk(clk), .rst(rst), .clr(lane_clr), .en(lane_en), .idx(lane_idx),
      .din(noncexSI[0]), .data(noncexDO)
   );

   ascon_lane_deser #(.W(l), .CW(CW)) u_ad (
      .clk(clk), .rst(rst), .clr(lane_clr), .en(lane_en), .idx(lane_idx),
      .din(associated_dataxSI[0]), .data(adxDO)
   );

   ascon_lane_deser #(.W(y), .CW(CW)) u_pt (
      .clk(clk), .rst(rst), .clr(lane_clr), .en(lane_en), .idx(lane_idx),
      .din(plain_textxSI[0]), .data(ptxDO)
   );

   assign loadedxSO      = loaded_q;
   assign core_startxSO  = core_start_q;
   assign cipher_textxSO = ct_q[0];
   assign tagxSO         = tag_q[0];
   assign out_validxSO   = out_valid_q;

endmodule

// File: tb/tb_ascon_serial_io.sv
// tb/tb_ascon_serial_io.sv - directed self-checking bench for ascon_serial_io
module tb_ascon_serial_io;

   localparam logic [127:0] K0  = 128'h5362006eff0b33bc8bb9950abdb242fc;
   localparam logic [127:0] N0  = 128'h1ccfafbc6dc738283ca9fe21ce0fccaa;
   localparam logic [39:0]  A0  = 40'h4153434f4e;
   localparam logic [95:0]  P0  = 96'h48656c6c6f20576f726c6421;
   localparam logic [127:0] K1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] N1  = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
   localparam logic [39:0]  A1  = 40'h8000000001;
   localparam logic [95:0]  P1  = 96'hdeadbeefcafef00d12345678;
   localparam logic [95:0]  CT0 = 96'ha5a5a5a53c3cc3c30f1e2d4b;
   localparam logic [127:0] TG0 = 128'h0123456789abcdef0123456789abcdef;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [4:0]   keyxSI = '0, noncexSI = '0, associated_dataxSI = '0, plain_textxSI = '0;
   logic         load_enxSI = 1'b0, startxSI = 1'b0, read_enxSI = 1'b0, core_readyxSI = 1'b0;
   logic [95:0]  core_ctxDI = '0;
   logic [127:0] core_tagxDI = '0;
   logic [127:0] keyxDO;
   logic [127:0] noncexDO;
   logic [39:0]  adxDO;
   logic [95:0]  ptxDO;
   logic         loadedxSO, core_startxSO, cipher_textxSO, tagxSO, out_validxSO;

   int vec = 0;
   int err = 0;
   int pulse_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (core_startxSO) pulse_cnt <= pulse_cnt + 1;

   ascon_serial_io dut (
      .clk(clk), .rst(rst),
      .keyxSI(keyxSI), .noncexSI(noncexSI),
      .associated_dataxSI(associated_dataxSI), .plain_textxSI(plain_textxSI),
      .load_enxSI(load_enxSI), .startxSI(startxSI), .read_enxSI(read_enxSI),
      .core_readyxSI(core_readyxSI), .core_ctxDI(core_ctxDI), .core_tagxDI(core_tagxDI),
      .keyxDO(keyxDO), .noncexDO(noncexDO), .adxDO(adxDO), .ptxDO(ptxDO),
      .loadedxSO(loadedxSO), .core_startxSO(core_startxSO),
      .cipher_textxSO(cipher_textxSO), .tagxSO(tagxSO), .out_validxSO(out_validxSO)
   );

   function automatic logic [3:0] pad(input int mode);
      if (mode == 1) return 4'h0;
      if (mode == 2) return 4'hf;
      return 4'($urandom);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic load_frame(input logic [127:0] kv, input logic [127:0] nv,
                             input logic [39:0] av, input logic [95:0] pv, input int pm);
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         if (i == 127) begin
            vec++;
            if (loadedxSO !== 1'b0) begin
               err++;
               $display("FAIL loaded_early: got %b want 0", loadedxSO);
            end
         end
         keyxSI             = {pad(pm), kv[127-i]};
         noncexSI           = {pad(pm), nv[127-i]};
         associated_dataxSI = {pad(pm), (i < 40) ? av[39-i] : 1'($urandom)};
         plain_textxSI      = {pad(pm), (i < 96) ? pv[95-i] : 1'($urandom)};
         load_enxSI         = 1'b1;
      end
      @(negedge clk);
      load_enxSI = 1'b0;
      vec++;
      if (loadedxSO !== 1'b1) begin
         err++;
         $display("FAIL loaded_rise: got %b want 1", loadedxSO);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      startxSI = 1'b1;
      @(negedge clk);
      startxSI = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if ({keyxDO, noncexDO, adxDO, ptxDO, loadedxSO, core_startxSO, cipher_textxSO, tagxSO, out_validxSO} !== '0) begin
         err++;
         $display("FAIL reset_outputs: got nonzero outputs, want all 0");
      end
      rst = 1'b1;
   endtask

   task automatic test_load();
      load_frame(K0, N0, A0, P0, 0);
      vec++;
      if (keyxDO !== K0) begin err++; $display("FAIL load_key: got %h want %h", keyxDO, K0); end
      vec++;
      if (noncexDO !== N0) begin err++; $display("FAIL load_nonce: got %h want %h", noncexDO, N0); end
      vec++;
      if (adxDO !== A0) begin err++; $display("FAIL load_ad: got %h want %h", adxDO, A0); end
      vec++;
      if (ptxDO !== P0) begin err++; $display("FAIL load_pt: got %h want %h", ptxDO, P0); end
   endtask

   task automatic test_padding();
      for (int m = 1; m <= 2; m++) begin
         do_reset();
         load_frame(K0, N0, A0, P0, m);
         vec++;
         if ({keyxDO, noncexDO, adxDO, ptxDO} !== {K0, N0, A0, P0}) begin
            err++;
            $display("FAIL padding_mode%0d: got %h %h %h %h want %h %h %h %h",
                     m, keyxDO, noncexDO, adxDO, ptxDO, K0, N0, A0, P0);
         end
      end
   endtask

   task automatic test_start();
      int base;
      do_reset();
      base = pulse_cnt;
      startxSI      = 1'b1;
      core_readyxSI = 1'b1;
      load_frame(K0, N0, A0, P0, 0);
      repeat (3) @(negedge clk);
      vec++;
      if (pulse_cnt - base !== 0) begin
         err++;
         $display("FAIL start_early: got %0d pulses want 0", pulse_cnt - base);
      end
      vec++;
      if (out_validxSO !== 1'b0) begin
         err++;
         $display("FAIL ready_outside_run: got %b want 0", out_validxSO);
      end
      core_readyxSI = 1'b0;
      startxSI      = 1'b0;
      @(negedge clk);
      startxSI = 1'b1;
      repeat (5) @(negedge clk);
      startxSI = 1'b0;
      repeat (2) @(negedge clk);
      vec++;
      if (pulse_cnt - base !== 1) begin
         err++;
         $display("FAIL start_pulse: got %0d pulse cycles want 1", pulse_cnt - base);
      end
      vec++;
      if (out_validxSO !== 1'b0) begin
         err++;
         $display("FAIL run_wait: got out_valid %b want 0", out_validxSO);
      end
   endtask

   task automatic test_unload();
      logic exp_ct;
      logic [127:0] ct_rx;
      logic [127:0] tg_rx;
      @(negedge clk);
      core_ctxDI    = CT0;
      core_tagxDI   = TG0;
      core_readyxSI = 1'b1;
      @(negedge clk);
      core_readyxSI = 1'b0;
      core_ctxDI    = '0;
      core_tagxDI   = '0;
      ct_rx = '0;
      tg_rx = '0;
      for (int i = 0; i < 128; i++) begin
         exp_ct = (i < 96) ? CT0[i] : 1'b0;
         vec++;
         if ({out_validxSO, cipher_textxSO, tagxSO} !== {1'b1, exp_ct, TG0[i]}) begin
            err++;
            $display("FAIL unload_bit%0d: got v/ct/tag %b%b%b want %b%b%b",
                     i, out_validxSO, cipher_textxSO, tagxSO, 1'b1, exp_ct, TG0[i]);
         end
         ct_rx[i] = cipher_textxSO;
         tg_rx[i] = tagxSO;
         read_enxSI = 1'b1;
         load_enxSI = 1'b1;
         keyxSI     = 5'($urandom);
         noncexSI   = 5'($urandom);
         @(negedge clk);
         read_enxSI = 1'b0;
         load_enxSI = 1'b0;
         if ((i % 4) == 0 && i < 127) begin
            @(negedge clk);
            vec++;
            if ({cipher_textxSO, tagxSO} !== {((i + 1) < 96) ? CT0[i+1] : 1'b0, TG0[i+1]}) begin
               err++;
               $display("FAIL read_hold%0d: got ct/tag %b%b want %b%b", i, cipher_textxSO, tagxSO,
                        ((i + 1) < 96) ? CT0[i+1] : 1'b0, TG0[i+1]);
            end
         end
      end
      vec++;
      if (ct_rx !== {32'h0, CT0}) begin err++; $display("FAIL ct_reassembled: got %h want %h", ct_rx, {32'h0, CT0}); end
      vec++;
      if (tg_rx !== TG0) begin err++; $display("FAIL tag_reassembled: got %h want %h", tg_rx, TG0); end
      vec++;
      if ({out_validxSO, loadedxSO, cipher_textxSO, tagxSO} !== 4'b0000) begin
         err++;
         $display("FAIL done_outputs: got %b want 0000", {out_validxSO, loadedxSO, cipher_textxSO, tagxSO});
      end
      vec++;
      if ({keyxDO, noncexDO} !== {K0, N0}) begin
         err++;
         $display("FAIL read_wins: got %h %h want %h %h", keyxDO, noncexDO, K0, N0);
      end
   endtask

   task automatic test_reload_after_done();
      load_frame(K1, N1, A1, P1, 0);
      vec++;
      if ({keyxDO, noncexDO, adxDO, ptxDO} !== {K1, N1, A1, P1}) begin
         err++;
         $display("FAIL reload: got %h %h %h %h want %h %h %h %h",
                  keyxDO, noncexDO, adxDO, ptxDO, K1, N1, A1, P1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         keyxSI     = {4'h0, K0[127-i]};
         noncexSI   = {4'h0, N0[127-i]};
         load_enxSI = 1'b1;
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      load_enxSI = 1'b0;
      vec++;
      if ({keyxDO, noncexDO, adxDO, ptxDO, loadedxSO, core_startxSO, cipher_textxSO, tagxSO, out_validxSO} !== '0) begin
         err++;
         $display("FAIL reset_mid_load: outputs not cleared, key %h", keyxDO);
      end
      @(negedge clk);
      rst = 1'b1;
      load_frame(K0, N0, A0, P0, 0);
      do_start();
      core_ctxDI    = CT0;
      core_tagxDI   = TG0;
      core_readyxSI = 1'b1;
      @(negedge clk);
      core_readyxSI = 1'b0;
      read_enxSI    = 1'b1;
      repeat (5) @(negedge clk);
      read_enxSI = 1'b0;
      vec++;
      if (out_validxSO !== 1'b1) begin err++; $display("FAIL unload_before_reset: got %b want 1", out_validxSO); end
      #2 rst = 1'b0;
      #1;
      vec++;
      if ({keyxDO, noncexDO, adxDO, ptxDO, loadedxSO, core_startxSO, cipher_textxSO, tagxSO, out_validxSO} !== '0) begin
         err++;
         $display("FAIL reset_mid_unload: outputs not cleared, valid %b", out_validxSO);
      end
      @(negedge clk);
      rst = 1'b1;
      load_frame(K1, N1, A1, P1, 0);
      vec++;
      if ({keyxDO, noncexDO, adxDO, ptxDO} !== {K1, N1, A1, P1}) begin
         err++;
         $display("FAIL fresh_load: got %h %h %h %h want %h %h %h %h",
                  keyxDO, noncexDO, adxDO, ptxDO, K1, N1, A1, P1);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_padding();
      test_start();
      test_unload();
      test_reload_after_done();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
